// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer: expands one host or auto-poll request
// into START/WRITE/READ/STOP engine operations with NACK retry and timeout.
module i2c_txn_sequencer #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h26,
    parameter logic [7:0] POLL_REG      = 8'h00,
    parameter int         POLL_INTERVAL = 5_000_000,
    parameter int         MAX_RETRY     = 3,
    parameter int         ENG_TIMEOUT   = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       REQ_RW,
    input  logic [7:0] REQ_REG,
    input  logic [7:0] REQ_WDATA,
    input  logic       AUTO_POLL,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       POLLED,
    output logic [7:0] RDATA,
    output logic       ENG_START,
    output logic [1:0] ENG_OP,
    output logic [7:0] ENG_TX,
    input  logic       ENG_BUSY,
    input  logic       ENG_ACK,
    input  logic [7:0] ENG_RX
);
    localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_READ = 2'd2, OP_WRITE = 2'd3;
    localparam int PW = $clog2(POLL_INTERVAL);
    localparam int TW = $clog2(ENG_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, FINISH} state_t;

    state_t        state;
    logic [2:0]    step, nxt_step, last_step;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tmr;
    logic [PW-1:0] poll_cnt;
    logic          poll_pend, poll_tick, seen_busy, nack;
    logic          txn_rw, txn_poll, can_take, take_host, take_poll;
    logic [7:0]    txn_reg, txn_wdata, shadow;

    function automatic logic [1:0] step_op(input logic [2:0] s, input logic rd);
        logic [1:0] op;
        op = OP_STOP;
        if (rd) begin
            case (s)
                3'd0, 3'd3:       op = OP_START;
                3'd1, 3'd2, 3'd4: op = OP_WRITE;
                3'd5:             op = OP_READ;
                default:          op = OP_STOP;
            endcase
        end else begin
            case (s)
                3'd0:             op = OP_START;
                3'd1, 3'd2, 3'd3: op = OP_WRITE;
                default:          op = OP_STOP;
            endcase
        end
        return op;
    endfunction

    function automatic logic [7:0] step_tx(input logic [2:0] s, input logic rd,
                                           input logic [7:0] rg, input logic [7:0] wd);
        logic [7:0] tx;
        case (s)
            3'd1:    tx = {SLAVE_ADDR, 1'b0};
            3'd2:    tx = rg;
            3'd3:    tx = rd ? 8'hFF : wd;
            3'd4:    tx = rd ? {SLAVE_ADDR, 1'b1} : 8'hFF;
            default: tx = 8'hFF;
        endcase
        return tx;
    endfunction

    // FINISH accepts like IDLE so a back-to-back request starts one cycle after DONE
    assign can_take  = (state == IDLE) || (state == FINISH);
    assign take_host = can_take && REQ;
    assign take_poll = can_take && !REQ && poll_pend;
    assign last_step = txn_rw ? 3'd6 : 3'd4;
    assign poll_tick = (poll_cnt == PW'(POLL_INTERVAL - 1));

    always_comb begin
        nxt_step = step + 3'd1;
        if (ENG_OP == OP_STOP)
            nxt_step = 3'd0;
        else if (ENG_OP == OP_WRITE && !ENG_ACK)
            nxt_step = last_step;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (!AUTO_POLL) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            poll_cnt  <= poll_tick ? '0 : poll_cnt + 1'b1;
            poll_pend <= poll_tick | (poll_pend & ~take_poll);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            step      <= '0;
            retry_cnt <= '0;
            tmr       <= '0;
            seen_busy <= 1'b0;
            nack      <= 1'b0;
            txn_rw    <= 1'b0;
            txn_poll  <= 1'b0;
            txn_reg   <= '0;
            txn_wdata <= '0;
            shadow    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            POLLED    <= 1'b0;
            RDATA     <= '0;
            ENG_START <= 1'b0;
            ENG_OP    <= OP_STOP;
            ENG_TX    <= 8'hFF;
        end else begin
            ENG_START <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    DONE      <= 1'b0;
                    retry_cnt <= '0;
                    state     <= IDLE;
                    if (take_host || take_poll) begin
                        txn_rw    <= take_host ? REQ_RW : 1'b1;
                        txn_reg   <= take_host ? REQ_REG : POLL_REG;
                        txn_wdata <= REQ_WDATA;
                        txn_poll  <= take_poll;
                        nack      <= 1'b0;
                        step      <= '0;
                        BUSY      <= 1'b1;
                        ENG_START <= 1'b1;
                        ENG_OP    <= OP_START;
                        ENG_TX    <= 8'hFF;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmr       <= '0;
                    seen_busy <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    tmr <= tmr + 1'b1;
                    if (ENG_BUSY)
                        seen_busy <= 1'b1;
                    if (seen_busy && !ENG_BUSY) begin
                        state <= EVAL;
                    end else if (tmr == TW'(ENG_TIMEOUT - 1)) begin
                        // engine is stuck: abandon without a STOP
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        ERR    <= 1'b1;
                        POLLED <= txn_poll;
                        state  <= FINISH;
                    end
                end
                EVAL: begin
                    if (ENG_OP == OP_STOP && !(nack && retry_cnt < RW'(MAX_RETRY))) begin
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        ERR    <= nack;
                        POLLED <= txn_poll;
                        if (!nack && txn_rw)
                            RDATA <= shadow;
                        state  <= FINISH;
                    end else begin
                        if (ENG_OP == OP_STOP) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            nack      <= 1'b0;
                        end
                        if (ENG_OP == OP_READ)
                            shadow <= ENG_RX;
                        if (ENG_OP == OP_WRITE && !ENG_ACK)
                            nack <= 1'b1;
                        step      <= nxt_step;
                        ENG_OP    <= step_op(nxt_step, txn_rw);
                        ENG_TX    <= step_tx(nxt_step, txn_rw, txn_reg, txn_wdata);
                        ENG_START <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural engine that logs every
// operation it is handed; sequences are compared as packed op/byte words.
module tb_i2c_txn_sequencer;
    localparam int POLL_INTERVAL = 20;
    localparam int MAX_RETRY     = 3;
    localparam int ENG_TIMEOUT   = 64;

    logic       CLK = 1'b0, RST = 1'b0;
    logic       REQ = 1'b0, REQ_RW = 1'b0, AUTO_POLL = 1'b0;
    logic [7:0] REQ_REG = 8'h00, REQ_WDATA = 8'h00;
    logic       BUSY, DONE, ERR, POLLED, ENG_START;
    logic [1:0] ENG_OP;
    logic [7:0] RDATA, ENG_TX;
    logic       ENG_BUSY = 1'b0, ENG_ACK = 1'b1;
    logic [7:0] ENG_RX = 8'h00;

    i2c_txn_sequencer #(
        .SLAVE_ADDR(7'h26), .POLL_REG(8'h00), .POLL_INTERVAL(POLL_INTERVAL),
        .MAX_RETRY(MAX_RETRY), .ENG_TIMEOUT(ENG_TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_REG(REQ_REG),
        .REQ_WDATA(REQ_WDATA), .AUTO_POLL(AUTO_POLL), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .POLLED(POLLED), .RDATA(RDATA), .ENG_START(ENG_START),
        .ENG_OP(ENG_OP), .ENG_TX(ENG_TX), .ENG_BUSY(ENG_BUSY), .ENG_ACK(ENG_ACK),
        .ENG_RX(ENG_RX)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // engine model: 2 busy cycles per op, NACKs slave-address writes while naddr < nack_until
    logic [1:0] op_q[$];
    logic [7:0] tx_q[$];
    int naddr = 0, nack_until = 0;
    bit hang = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ENG_START) begin
                op_q.push_back(ENG_OP);
                if (ENG_OP == 2'd3) begin
                    tx_q.push_back(ENG_TX);
                    if (ENG_TX[7:1] == 7'h26) begin
                        ENG_ACK = (naddr >= nack_until);
                        naddr++;
                    end else begin
                        ENG_ACK = 1'b1;
                    end
                end
                ENG_BUSY = 1'b1;
                repeat (2) @(posedge CLK);
                while (hang) @(posedge CLK);
                #1 ENG_BUSY = 1'b0;
            end
        end
    end

    function automatic logic [31:0] ops_from(input int base);
        logic [31:0] v = 32'h0;
        for (int i = base; i < op_q.size(); i++) v = (v << 2) | 32'(op_q[i]);
        return v;
    endfunction

    function automatic logic [31:0] txs_from(input int base);
        logic [31:0] v = 32'h0;
        for (int i = base; i < tx_q.size(); i++) v = (v << 8) | 32'(tx_q[i]);
        return v;
    endfunction

    int   op_base = 0, tx_base = 0, acc_lat = 0;
    logic st_acc = 1'b0;
    logic [1:0] op_acc = 2'd0;

    task automatic start_req(input logic rw, input logic [7:0] rg, input logic [7:0] wd);
        int n = 0;
        op_base = op_q.size();
        tx_base = tx_q.size();
        REQ = 1'b1; REQ_RW = rw; REQ_REG = rg; REQ_WDATA = wd;
        do begin @(negedge CLK); n++; end while (!BUSY && n < 20);
        if (!BUSY) check("accept_timeout", 32'(BUSY), 32'd1);
        acc_lat = n; st_acc = ENG_START; op_acc = ENG_OP;
        // scramble the request fields: the transaction must run on latched copies
        REQ = 1'b0; REQ_RW = ~rw; REQ_REG = 8'hEE; REQ_WDATA = 8'hEE;
    endtask

    task automatic wait_done(output logic e, output logic p, output logic [7:0] r, output int lat);
        lat = 0;
        do begin @(negedge CLK); lat++; end while (!DONE && lat < 3000);
        if (!DONE) check("done_timeout", 32'(DONE), 32'd1);
        e = ERR; p = POLLED; r = RDATA;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e, p;
        logic [7:0] r;
        int lat, n;

        repeat (3) @(negedge CLK);
        check("rst_busy",  32'(BUSY),   32'd0);
        check("rst_done",  32'(DONE),   32'd0);
        check("rst_start", 32'(ENG_START), 32'd0);
        check("rst_op",    32'(ENG_OP), 32'd1);
        check("rst_tx",    32'(ENG_TX), 32'hFF);
        check("rst_rdata", 32'(RDATA),  32'h00);
        RST = 1'b1;
        @(negedge CLK);

        // register write, all ACK
        nack_until = naddr;
        start_req(1'b0, 8'h10, 8'hA5);
        check("wr_acc_lat",   32'(acc_lat), 32'd1);
        check("wr_acc_start", 32'(st_acc),  32'd1);
        check("wr_acc_op",    32'(op_acc),  32'd0);
        wait_done(e, p, r, lat);
        check("wr_busy_at_done", 32'(BUSY), 32'd0);
        check("wr_ops",   ops_from(op_base), 32'h0FD);
        check("wr_tx",    txs_from(tx_base), 32'h4C10A5);
        check("wr_err",   32'(e), 32'd0);
        check("wr_rdata", 32'(r), 32'h00);

        // register read, engine returns 3C
        ENG_RX = 8'h3C;
        start_req(1'b1, 8'h02, 8'h00);
        wait_done(e, p, r, lat);
        check("rd_ops",    ops_from(op_base), 32'hF39);
        check("rd_tx",     txs_from(tx_base), 32'h4C024D);
        check("rd_err",    32'(e), 32'd0);
        check("rd_polled", 32'(p), 32'd0);
        check("rd_rdata",  32'(r), 32'h3C);

        // address NACK on every attempt: 1 + MAX_RETRY triplets then ERR
        ENG_RX = 8'h77;
        nack_until = naddr + 100;
        start_req(1'b1, 8'h05, 8'h00);
        wait_done(e, p, r, lat);
        check("nack_ops_cnt", 32'(op_q.size() - op_base), 32'd12);
        check("nack_ops",     ops_from(op_base), 32'h34D34D);
        check("nack_err",     32'(e), 32'd1);
        check("nack_rdata",   32'(r), 32'h3C);

        // NACK once, then ACK: one retry then a full write
        nack_until = naddr + 1;
        start_req(1'b0, 8'h10, 8'h55);
        wait_done(e, p, r, lat);
        check("retry_ops", ops_from(op_base), 32'h34FD);
        check("retry_tx",  txs_from(tx_base), 32'h4C4C1055);
        check("retry_err", 32'(e), 32'd0);

        // auto-poll alone: tick after POLL_INTERVAL cycles, accept on the next
        ENG_RX = 8'h99;
        tx_base = tx_q.size();
        AUTO_POLL = 1'b1;
        n = 0;
        do begin @(posedge CLK); n++; @(negedge CLK); end while (!ENG_START && n < 100);
        check("poll_start_lat", 32'(n), 32'd21);
        AUTO_POLL = 1'b0;
        wait_done(e, p, r, lat);
        check("poll_polled", 32'(p), 32'd1);
        check("poll_err",    32'(e), 32'd0);
        check("poll_rdata",  32'(r), 32'h99);
        check("poll_tx",     txs_from(tx_base), 32'h4C004D);

        // host REQ on the tick edge wins; the poll follows
        ENG_RX = 8'hC3;
        @(negedge CLK);
        AUTO_POLL = 1'b1;
        repeat (19) @(posedge CLK);
        @(negedge CLK);
        start_req(1'b0, 8'h20, 8'h11);
        check("hp_acc_lat", 32'(acc_lat), 32'd1);
        wait_done(e, p, r, lat);
        check("hp_host_polled", 32'(p), 32'd0);
        check("hp_host_tx",     txs_from(tx_base), 32'h4C2011);
        tx_base = tx_q.size();
        n = 0;
        do begin @(negedge CLK); n++; end while (!BUSY && n < 20);
        check("hp_poll_follows", 32'(BUSY), 32'd1);
        AUTO_POLL = 1'b0;
        wait_done(e, p, r, lat);
        check("hp_poll_polled", 32'(p), 32'd1);
        check("hp_poll_tx",     txs_from(tx_base), 32'h4C004D);
        check("hp_poll_rdata",  32'(r), 32'hC3);

        // engine stuck busy: timeout, no STOP issued
        hang = 1'b1;
        start_req(1'b0, 8'h30, 8'h01);
        wait_done(e, p, r, lat);
        check("to_err",     32'(e), 32'd1);
        check("to_lat",     32'(lat >= ENG_TIMEOUT && lat <= ENG_TIMEOUT + 3), 32'd1);
        check("to_ops_cnt", 32'(op_q.size() - op_base), 32'd1);
        check("to_no_stop", ops_from(op_base), 32'h0);

        // reset in the middle of a transaction clears outputs immediately
        start_req(1'b1, 8'h40, 8'h00);
        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        hang = 1'b0;
        #1;
        check("arst_busy",  32'(BUSY),   32'd0);
        check("arst_err",   32'(ERR),    32'd0);
        check("arst_op",    32'(ENG_OP), 32'd1);
        check("arst_tx",    32'(ENG_TX), 32'hFF);
        check("arst_rdata", 32'(RDATA),  32'h00);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_idle", 32'(BUSY | ENG_START), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
